adma_dm_axi_b_trk: RTL
======================

# adma_dm_axi_b_trk

Out-of-order AXI write-response (B channel) tracker for the DMA data mover, sitting between the AW issue logic and the channel controllers. Each issued write transaction occupies a slot in an outstanding table. Incoming B responses are matched by ID, in per-ID issue order, with no reorder buffer. For each matched response the block reports a per-channel done pulse, an error pulse, and a per-channel outstanding count. It also runs a per-slot response watchdog.

## Interface
- DMA_CHN_NUM, 4: number of DMA channels.
- MST_ID_W, 5: AXI ID width.
- ATX_RESP_W, 2: BRESP width (fixed at 2).
- ATX_NUM_OSTD, 8: outstanding table depth (slots); at least 2.
- TMO_W, 16: watchdog counter width.
- DMA_CHN_NUM_W, derived: (DMA_CHN_NUM>1) ? $clog2(DMA_CHN_NUM) : 1.
- OSTD_CNT_W, derived: $clog2(ATX_NUM_OSTD+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- atx_chn_id  in  DMA_CHN_NUM_W  channel of the issued AW transaction.
- atx_awid  in  MST_ID_W  AWID of the issued transaction.
- atx_vld  in  1  issue request.
- atx_rdy  out  1  a free slot exists.
- tmo_lim  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
- atx_done  out  [0:DMA_CHN_NUM-1] x 1  one-cycle pulse: a response has retired for that channel.
- atx_dst_err  out  [0:DMA_CHN_NUM-1] x 1  one-cycle pulse alongside done when BRESP is SLVERR or DECERR.
- atx_tmo  out  [0:DMA_CHN_NUM-1] x 1  one-cycle pulse: a slot of that channel reached tmo_lim.
- chn_ostd_cnt  out  [0:DMA_CHN_NUM-1] x OSTD_CNT_W  outstanding transactions per channel.
- unexp_rsp  out  1  one-cycle pulse: a B response matched no slot.
- m_bid_i  in  MST_ID_W  BID.
- m_bresp_i  in  ATX_RESP_W  BRESP.
- m_bvalid_i  in  1  BVALID.
- m_bready_o  out  1  BREADY.

## Operation
- Slot state: vld, chn, id, rank, tmo_cnt (TMO_W bits), tmo_fired.
- Allocation: when atx_vld & atx_rdy, take the lowest-index free slot.
  - rank = number of valid slots with the same id, excluding any slot retiring this cycle.
  - atx_rdy = ~rst & (some slot free), evaluated before this cycle's retire. A retiring slot is not reusable in the same cycle.
- Match: on a B handshake (m_bvalid_i & m_bready_o), select the single slot with vld & id==m_bid_i & rank==0.
  - That slot retires: vld is cleared.
  - Every other valid slot with the same id decrements its rank.
- No matching slot: the response is still accepted, unexp_rsp pulses, and no done or error is reported.
- m_bready_o = ~rst. The block never back-pressures B.
- Error decode: BRESP 2'b10 (SLVERR) or 2'b11 (DECERR) raise atx_dst_err. EXOKAY is treated as OKAY.
- Watchdog: tmo_cnt increments each cycle while the slot is valid and saturates at all-ones.
  - When tmo_lim!=0, tmo_cnt==tmo_lim and tmo_fired==0: pulse atx_tmo[chn] and set tmo_fired.
  - The slot stays valid until its response arrives.
  - Allocation clears tmo_cnt and tmo_fired.
- chn_ostd_cnt[c] is +1 on allocation to c and -1 on retire from c. Both in the same cycle on the same channel leave it unchanged.
- Multiple channels may pulse atx_tmo in the same cycle. atx_done and atx_dst_err have at most one channel active per cycle.

## Timing
- Reset (rst high at an edge): all slots invalid; ranks and counters 0; all pulses, counts and unexp_rsp 0. atx_rdy and m_bready_o are 0 while rst is high.
- Issue handshake at edge N: the slot is valid and chn_ostd_cnt is updated from cycle N+1.
- B handshake at edge M: atx_done, atx_dst_err and unexp_rsp are registered and high during cycle M+1 only.
- Latency is one cycle, with full throughput of one issue plus one response per cycle.
- A response arriving in the same cycle as the issue of its own ID does not see the new slot. It is reported as unexpected; this is a protocol violation upstream.
- Watchdog pulse: registered, in the cycle after tmo_cnt reaches tmo_lim.
- Table full: atx_rdy is 0. It rises the cycle after a retire edge.

## Test plan
- Reset, then issue IDs 3/ch0, 5/ch1, 7/ch2; respond 7, 3, 5 with OKAY -> done pulses ch2, ch0, ch1 at the edge after each response; chn_ostd_cnt returns to 0.
- Issue ID 2 on ch0 then ch3; respond ID 2 SLVERR, then ID 2 OKAY -> first response gives done+err on ch0; second gives done on ch3 only.
- Fill all 8 slots -> atx_rdy=0. Respond one slot while atx_vld is held -> atx_rdy=1 the next cycle and the new issue takes the freed slot index.
- tmo_lim=10, issue on ch1 with no response -> atx_tmo[1] pulses exactly once, 10 cycles after allocation. A late response still gives done[1]. With tmo_lim=0, no pulse ever occurs.
- BID 9 with no slot holding ID 9 -> unexp_rsp pulses; no done; counts unchanged.
- Same-cycle issue on ch1 and retire from ch1 -> chn_ostd_cnt[1] unchanged. Assert rst mid-traffic -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/adma_dm_axi_b_trk_if.sv
// AXI write-response (B) channel bundle between the interconnect and the B tracker.
// The master modport is the AXI-master side that consumes responses.
interface adma_dm_axi_b_trk_if #(
  parameter int MST_ID_W   = 5,
  parameter int ATX_RESP_W = 2
) ();
  logic [MST_ID_W-1:0]   m_bid_i;
  logic [ATX_RESP_W-1:0] m_bresp_i;
  logic                  m_bvalid_i;
  logic                  m_bready_o;

  modport master (
    input  m_bid_i,
    input  m_bresp_i,
    input  m_bvalid_i,
    output m_bready_o
  );

  modport slave (
    output m_bid_i,
    output m_bresp_i,
    output m_bvalid_i,
    input  m_bready_o
  );
endinterface

// File: rtl/adma_dm_axi_b_trk.sv
// Out-of-order AXI B-response tracker: slot table matched by ID in per-ID issue order,
// per-channel done/error/timeout pulses and outstanding counts.
module adma_dm_axi_b_trk #(
  parameter int DMA_CHN_NUM  = 4,
  parameter int MST_ID_W     = 5,
  parameter int ATX_RESP_W   = 2,
  parameter int ATX_NUM_OSTD = 8,
  parameter int TMO_W        = 16,
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  localparam int OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1),
  localparam int SLOT_W        = $clog2(ATX_NUM_OSTD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  input  logic [MST_ID_W-1:0]      atx_awid,
  input  logic                     atx_vld,
  output logic                     atx_rdy,
  input  logic [TMO_W-1:0]         tmo_lim,
  output logic                     atx_done     [0:DMA_CHN_NUM-1],
  output logic                     atx_dst_err  [0:DMA_CHN_NUM-1],
  output logic                     atx_tmo      [0:DMA_CHN_NUM-1],
  output logic [OSTD_CNT_W-1:0]    chn_ostd_cnt [0:DMA_CHN_NUM-1],
  output logic                     unexp_rsp,
  adma_dm_axi_b_trk_if.master      m_b
);

  logic [ATX_NUM_OSTD-1:0]  r_vld;
  logic [DMA_CHN_NUM_W-1:0] r_chn       [ATX_NUM_OSTD];
  logic [MST_ID_W-1:0]      r_id        [ATX_NUM_OSTD];
  logic [OSTD_CNT_W-1:0]    r_rank      [ATX_NUM_OSTD];
  logic [TMO_W-1:0]         r_tmo_cnt   [ATX_NUM_OSTD];
  logic [ATX_NUM_OSTD-1:0]  r_tmo_fired;

  logic                     w_b_hs;
  logic                     w_hit;
  logic [SLOT_W-1:0]        w_hit_idx;
  logic                     w_free_any;
  logic [SLOT_W-1:0]        w_free_idx;
  logic                     w_alloc;
  logic                     w_retire;
  logic [DMA_CHN_NUM_W-1:0] w_hit_chn;
  logic [OSTD_CNT_W-1:0]    w_new_rank;
  logic                     w_bresp_err;
  logic [ATX_NUM_OSTD-1:0]  w_tmo_hit;
  logic [DMA_CHN_NUM-1:0]   w_tmo_chn;

  assign m_b.m_bready_o = ~rst;
  assign w_b_hs         = m_b.m_bvalid_i & m_b.m_bready_o;
  assign atx_rdy        = ~rst & w_free_any;
  assign w_alloc        = atx_vld & atx_rdy;
  assign w_retire       = w_b_hs & w_hit;
  assign w_hit_chn      = r_chn[w_hit_idx];
  assign w_bresp_err    = (m_b.m_bresp_i == 2'b10) | (m_b.m_bresp_i == 2'b11);

  // Descending scan so the lowest index wins for both the match and the free slot.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = ATX_NUM_OSTD - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_id[i] == m_b.m_bid_i) && (r_rank[i] == '0)) begin
        w_hit     = 1'b1;
        w_hit_idx = SLOT_W'(i);
      end
      if (!r_vld[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  // New rank counts same-ID slots that survive this cycle, so it already accounts for a retire.
  always_comb begin
    w_new_rank = '0;
    for (int i = 0; i < ATX_NUM_OSTD; i++) begin
      if (r_vld[i] && (r_id[i] == atx_awid) &&
          !(w_retire && (w_hit_idx == SLOT_W'(i)))) begin
        w_new_rank = w_new_rank + OSTD_CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ATX_NUM_OSTD; gi++) begin : g_tmo_hit
      assign w_tmo_hit[gi] = r_vld[gi] & (tmo_lim != '0) &
                             (r_tmo_cnt[gi] == tmo_lim) & ~r_tmo_fired[gi];
    end
    for (gi = 0; gi < DMA_CHN_NUM; gi++) begin : g_tmo_chn
      always_comb begin
        w_tmo_chn[gi] = 1'b0;
        for (int i = 0; i < ATX_NUM_OSTD; i++) begin
          if (w_tmo_hit[i] && (r_chn[i] == DMA_CHN_NUM_W'(gi))) begin
            w_tmo_chn[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_tmo_fired <= '0;
      for (int i = 0; i < ATX_NUM_OSTD; i++) begin
        r_chn[i]     <= '0;
        r_id[i]      <= '0;
        r_rank[i]    <= '0;
        r_tmo_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ATX_NUM_OSTD; i++) begin
        if (w_alloc && (w_free_idx == SLOT_W'(i))) begin
          r_vld[i]       <= 1'b1;
          r_chn[i]       <= atx_chn_id;
          r_id[i]        <= atx_awid;
          r_rank[i]      <= w_new_rank;
          r_tmo_cnt[i]   <= '0;
          r_tmo_fired[i] <= 1'b0;
        end else if (r_vld[i]) begin
          if (r_tmo_cnt[i] != '1) begin
            r_tmo_cnt[i] <= r_tmo_cnt[i] + TMO_W'(1);
          end
          if (w_tmo_hit[i]) begin
            r_tmo_fired[i] <= 1'b1;
          end
          if (w_retire && (w_hit_idx == SLOT_W'(i))) begin
            r_vld[i] <= 1'b0;
          end else if (w_retire && (r_id[i] == m_b.m_bid_i)) begin
            r_rank[i] <= r_rank[i] - OSTD_CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unexp_rsp <= 1'b0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        atx_done[c]     <= 1'b0;
        atx_dst_err[c]  <= 1'b0;
        atx_tmo[c]      <= 1'b0;
        chn_ostd_cnt[c] <= '0;
      end
    end else begin
      unexp_rsp <= w_b_hs & ~w_hit;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        atx_done[c]     <= w_retire && (w_hit_chn == DMA_CHN_NUM_W'(c));
        atx_dst_err[c]  <= w_retire && (w_hit_chn == DMA_CHN_NUM_W'(c)) && w_bresp_err;
        atx_tmo[c]      <= w_tmo_chn[c];
        chn_ostd_cnt[c] <= chn_ostd_cnt[c]
                         + OSTD_CNT_W'(w_alloc && (atx_chn_id == DMA_CHN_NUM_W'(c)))
                         - OSTD_CNT_W'(w_retire && (w_hit_chn == DMA_CHN_NUM_W'(c)));
      end
    end
  end

endmodule
